// File: rtl/lru_tracker_n_if.sv
// Request/grant bundle between a buffer controller and the true-LRU tracker.
// Carries touch, alloc and invalidate channels for one WAYS x SETS array.
interface lru_tracker_n_if #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 8
);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic             touch_vld;
    logic [SET_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    logic             touch_rdy;

    logic             alloc_req;
    logic [SET_W-1:0] alloc_set;
    logic             alloc_rdy;
    logic             alloc_gnt;
    logic [WAY_W-1:0] alloc_way;

    logic             inval_vld;
    logic [SET_W-1:0] inval_set;
    logic [WAY_W-1:0] inval_way;

    modport master (
        output touch_vld, touch_set, touch_way,
        output alloc_req, alloc_set,
        output inval_vld, inval_set, inval_way,
        input  touch_rdy, alloc_rdy, alloc_gnt, alloc_way
    );

    modport slave (
        input  touch_vld, touch_set, touch_way,
        input  alloc_req, alloc_set,
        input  inval_vld, inval_set, inval_way,
        output touch_rdy, alloc_rdy, alloc_gnt, alloc_way
    );
endinterface

// File: rtl/lru_tracker_n.sv
// True-LRU replacement tracker: per-set recency list plus valid bits,
// with hit promotion, invalid-first victim allocation and invalidation.
module lru_tracker_n #(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    lru_tracker_n_if.slave   bus
);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic [WAY_W-1:0] order_q [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic             alloc_gnt_q;
    logic [WAY_W-1:0] alloc_way_q;

    logic             inval_acc;
    logic             alloc_acc;
    logic             touch_acc;
    logic             upd;
    logic [SET_W-1:0] op_set;
    logic [WAY_W-1:0] op_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] pos;
    logic             found_inv;
    logic [WAY_W-1:0] cur_order  [WAYS];
    logic [WAY_W-1:0] next_order [WAYS];
    logic [WAYS-1:0]  cur_valid;
    logic [WAYS-1:0]  next_valid;

    // Single-ported arbitration: inval over alloc over touch.
    always_comb begin
        inval_acc = bus.inval_vld;
        alloc_acc = bus.alloc_req & ~bus.inval_vld;
        touch_acc = bus.touch_vld & ~bus.inval_vld & ~bus.alloc_req;
        upd       = inval_acc | alloc_acc | touch_acc;
        op_set    = inval_acc ? bus.inval_set :
                    (alloc_acc ? bus.alloc_set : bus.touch_set);
        if (SETS == 1) begin
            op_set = '0;
        end
    end

    assign bus.alloc_rdy = ~bus.inval_vld;
    assign bus.touch_rdy = ~bus.inval_vld & ~bus.alloc_req;
    assign bus.alloc_gnt = alloc_gnt_q;
    assign bus.alloc_way = alloc_way_q;

    // Victim selection and the rotated order list for the selected set.
    always_comb begin
        cur_order  = order_q[op_set];
        cur_valid  = valid_q[op_set];
        victim     = cur_order[0];
        found_inv  = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!cur_valid[i] && !found_inv) begin
                victim    = WAY_W'(i);
                found_inv = 1'b1;
            end
        end

        op_way = inval_acc ? bus.inval_way : (alloc_acc ? victim : bus.touch_way);

        pos = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (cur_order[i] == op_way) begin
                pos = WAY_W'(i);
            end
        end

        next_order = cur_order;
        next_valid = cur_valid;
        if (inval_acc) begin
            // Demote to LRU: entries below the old slot move up one.
            next_order[0] = op_way;
            for (int unsigned i = 1; i < WAYS; i++) begin
                if (WAY_W'(i) <= pos) begin
                    next_order[i] = cur_order[i-1];
                end
            end
            next_valid[op_way] = 1'b0;
        end else begin
            // Promote to MRU: entries above the old slot move down one.
            for (int unsigned i = 0; i < WAYS - 1; i++) begin
                if (WAY_W'(i) >= pos) begin
                    next_order[i] = cur_order[i+1];
                end
            end
            next_order[WAYS-1] = op_way;
            next_valid[op_way] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    order_q[s][w] <= WAY_W'(w);
                end
                valid_q[s] <= '0;
            end
            alloc_gnt_q <= 1'b0;
            alloc_way_q <= '0;
        end else begin
            if (upd) begin
                order_q[op_set] <= next_order;
                valid_q[op_set] <= next_valid;
            end
            alloc_gnt_q <= alloc_acc;
            if (alloc_acc) begin
                alloc_way_q <= victim;
            end
        end
    end
endmodule

// File: tb/tb_lru_tracker_n.sv
// Bench for lru_tracker_n: directed scenarios on a 4x8 instance and random
// traffic on a 16x64 instance, both against a timestamp-based recency model.
module tb_lru_tracker_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lru_tracker_n_if #(.WAYS(4),  .SETS(8))  if4 ();
    lru_tracker_n_if #(.WAYS(16), .SETS(64)) if16 ();

    lru_tracker_n #(.WAYS(4),  .SETS(8))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    lru_tracker_n #(.WAYS(16), .SETS(64)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each way carries a last-use stamp; ascending stamp order = LRU..MRU.
    int mts  [2][64][16];
    bit mvld [2][64][16];
    int nw   [2] = '{4, 16};
    bit exp_gnt [2];
    int exp_way [2];
    int hi_stamp;
    int lo_stamp;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 64; s++) begin
                for (int w = 0; w < 16; w++) begin
                    mts[m][s][w]  = w;
                    mvld[m][s][w] = 1'b0;
                end
            end
            exp_gnt[m] = 1'b0;
            exp_way[m] = 0;
        end
        hi_stamp = 100;
        lo_stamp = -1;
    endtask

    function automatic int rank_way(input int m, input int s, input int r);
        for (int w = 0; w < nw[m]; w++) begin
            int cnt = 0;
            for (int v = 0; v < nw[m]; v++) begin
                if (mts[m][s][v] < mts[m][s][w]) cnt++;
            end
            if (cnt == r) return w;
        end
        return -1;
    endfunction

    function automatic int m_victim(input int m, input int s);
        for (int w = 0; w < nw[m]; w++) begin
            if (!mvld[m][s][w]) return w;
        end
        return rank_way(m, s, 0);
    endfunction

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_order(input int m, input int s);
        for (int r = 0; r < nw[m]; r++) begin
            int got;
            if (m == 0) got = int'(dut4.order_q[s][r]);
            else        got = int'(dut16.order_q[s][r]);
            chk($sformatf("order[m%0d s%0d r%0d]", m, s, r), got, rank_way(m, s, r));
        end
    endtask

    // One cycle: check last grant, present inputs, check ready, advance model.
    task automatic drive(input int m, input bit iv, input int is, input int iw,
                         input bit ar, input int as, input bit tv, input int tset, input int tw);
        bit nxt_gnt;
        @(negedge clk);
        if (m == 0) begin
            chk("gnt4", int'(if4.alloc_gnt), int'(exp_gnt[0]));
            chk("way4", int'(if4.alloc_way), exp_way[0]);
        end else begin
            chk("gnt16", int'(if16.alloc_gnt), int'(exp_gnt[1]));
            chk("way16", int'(if16.alloc_way), exp_way[1]);
        end
        if4.inval_vld = (m == 0) && iv;  if4.inval_set = 3'(is);   if4.inval_way = 2'(iw);
        if4.alloc_req = (m == 0) && ar;  if4.alloc_set = 3'(as);
        if4.touch_vld = (m == 0) && tv;  if4.touch_set = 3'(tset); if4.touch_way = 2'(tw);
        if16.inval_vld = (m == 1) && iv; if16.inval_set = 6'(is);   if16.inval_way = 4'(iw);
        if16.alloc_req = (m == 1) && ar; if16.alloc_set = 6'(as);
        if16.touch_vld = (m == 1) && tv; if16.touch_set = 6'(tset); if16.touch_way = 4'(tw);
        #1;
        if (m == 0) begin
            chk("alloc_rdy4", int'(if4.alloc_rdy), int'(!iv));
            chk("touch_rdy4", int'(if4.touch_rdy), int'(!iv && !ar));
        end else begin
            chk("alloc_rdy16", int'(if16.alloc_rdy), int'(!iv));
            chk("touch_rdy16", int'(if16.touch_rdy), int'(!iv && !ar));
        end
        nxt_gnt = 1'b0;
        if (iv) begin
            mts[m][is][iw]  = lo_stamp--;
            mvld[m][is][iw] = 1'b0;
        end else if (ar) begin
            int v = m_victim(m, as);
            mts[m][as][v]  = hi_stamp++;
            mvld[m][as][v] = 1'b1;
            nxt_gnt    = 1'b1;
            exp_way[m] = v;
        end else if (tv) begin
            mts[m][tset][tw]  = hi_stamp++;
            mvld[m][tset][tw] = 1'b1;
        end
        exp_gnt[m] = nxt_gnt;
        exp_gnt[1-m] = 1'b0;
    endtask

    task automatic alloc4(input int s, input int w_req);
        drive(0, 0, 0, 0, 1, s, 0, 0, 0);
        settle();
        chk("grant_const", int'(if4.alloc_gnt), 1);
        chk("way_const", int'(if4.alloc_way), w_req);
    endtask

    initial begin
        if4.inval_vld = 0;  if4.alloc_req = 0;  if4.touch_vld = 0;
        if4.inval_set = 0;  if4.inval_way = 0;  if4.alloc_set = 0;
        if4.touch_set = 0;  if4.touch_way = 0;
        if16.inval_vld = 0; if16.alloc_req = 0; if16.touch_vld = 0;
        if16.inval_set = 0; if16.inval_way = 0; if16.alloc_set = 0;
        if16.touch_set = 0; if16.touch_way = 0;
        m_reset();
        #12 rst_n = 1'b1;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_order(0, 0);

        // Fill set 0 in index order, then touch 0 and 2.
        alloc4(0, 0); alloc4(0, 1); alloc4(0, 2); alloc4(0, 3);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 2);
        alloc4(0, 1);
        alloc4(0, 3);
        chk_order(0, 0);

        // Invalid way wins, then true LRU.
        drive(0, 1, 0, 2, 0, 0, 0, 0, 0);
        alloc4(0, 2);
        alloc4(0, 0);

        // Collision: inval wins, alloc then touch are held and retired in order.
        drive(0, 1, 0, 1, 1, 0, 1, 0, 3);
        alloc4(0, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 3);
        settle();
        chk_order(0, 0);

        // Set isolation.
        alloc4(3, 0); alloc4(3, 1); alloc4(3, 2); alloc4(3, 3);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0);
        alloc4(5, 0);
        chk_order(0, 3);
        chk_order(0, 5);

        // Reset between alloc presentation and its grant edge.
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("gnt_in_reset", int'(if4.alloc_gnt), 0);
        settle();
        if4.alloc_req = 1'b0;
        chk("gnt_after_rst_edge", int'(if4.alloc_gnt), 0);
        chk("way_after_rst_edge", int'(if4.alloc_way), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk_order(0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        alloc4(0, 0);

        // Random traffic on the wide instance.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20000; c++) begin
            bit iv = ($urandom_range(0, 99) < 12);
            bit ar = ($urandom_range(0, 99) < 40);
            bit tv = ($urandom_range(0, 99) < 60);
            int is = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3);
            int as = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3);
            int ts = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3);
            int ws = iv ? is : (ar ? as : ts);
            drive(1, iv, is, $urandom_range(0, 15), ar, as, tv, ts, $urandom_range(0, 15));
            settle();
            if (c % 4 == 0) chk_order(1, ws);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
